// File: rtl/emc_xrom_fetch_pkg.sv
// ---------------------------------------------------------------------------
// emc_xrom_fetch_pkg
// Shared definitions for the EMC08 external program-ROM fetch controller:
//   - xrom_state_t     : 2-bit FSM state encoding (IDLE, ADDR, STROBE, DONE)
//   - WAIT_STATES_MAX  : largest legal number of extra strobe cycles
//   - XROM_RESET_ADDR  : address driven on the pads out of reset
//   - next_addr()      : sequential successor address, wrapping FFFF -> 0000
// ---------------------------------------------------------------------------
package emc_xrom_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ADDR   = 2'b01,
        ST_STROBE = 2'b10,
        ST_DONE   = 2'b11
    } xrom_state_t;

    localparam int          WAIT_STATES_MAX = 7;
    localparam logic [15:0] XROM_RESET_ADDR = 16'h0000;

    // The ROM is a flat 64K space with no banking, so the successor of the
    // top byte is simply address zero.
    function automatic logic [15:0] next_addr(input logic [15:0] addr);
        return addr + 16'h0001;
    endfunction

endpackage

// File: rtl/emc_xrom_fetch_if.sv
// ---------------------------------------------------------------------------
// emc_xrom_fetch_if
// Bundles the CPU fetch handshake and the ROM pad signals of the fetch
// controller.
//   CPU side : xrom_req_i, xrom_addr_i, xrom_abort_i  -> controller
//              xrom_ack_o, xrom_data_o, xrom_busy_o   <- controller
//   Pad side : xrom_adr_hi_o (P2), xrom_adr_lo_o (P4),
//              xrom_psen_b_o, xrom_oe_b_o (P3[7])     <- controller
//              xrom_data_i (P0)                       -> controller
// Modports: slave = the controller, master = fetch unit plus ROM/pads.
// ---------------------------------------------------------------------------
interface emc_xrom_fetch_if;

    logic        xrom_req_i;
    logic [15:0] xrom_addr_i;
    logic        xrom_abort_i;
    logic        xrom_ack_o;
    logic [7:0]  xrom_data_o;
    logic        xrom_busy_o;
    logic [7:0]  xrom_adr_hi_o;
    logic [7:0]  xrom_adr_lo_o;
    logic        xrom_psen_b_o;
    logic        xrom_oe_b_o;
    logic [7:0]  xrom_data_i;

    modport slave (
        input  xrom_req_i, xrom_addr_i, xrom_abort_i, xrom_data_i,
        output xrom_ack_o, xrom_data_o, xrom_busy_o,
               xrom_adr_hi_o, xrom_adr_lo_o, xrom_psen_b_o, xrom_oe_b_o
    );

    modport master (
        output xrom_req_i, xrom_addr_i, xrom_abort_i, xrom_data_i,
        input  xrom_ack_o, xrom_data_o, xrom_busy_o,
               xrom_adr_hi_o, xrom_adr_lo_o, xrom_psen_b_o, xrom_oe_b_o
    );

endinterface

// File: rtl/emc_xrom_pfbuf.sv
// ---------------------------------------------------------------------------
// emc_xrom_pfbuf
// One-entry prefetch buffer (tag, data, valid) with address compare.
// Ports:
//   clk, rst_n   : core clock, asynchronous active-low reset
//   wr_en        : store wr_tag/wr_data and mark the entry valid
//   clr          : invalidate the entry (wins over wr_en)
//   lookup_addr  : address to compare against the stored tag
//   hit, rd_data : entry valid and tag matches; stored byte
// Only instantiated when EMC_XROM_PREFETCH_EN is defined.
// ---------------------------------------------------------------------------
module emc_xrom_pfbuf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        clr,
    input  logic [15:0] wr_tag,
    input  logic [7:0]  wr_data,
    input  logic [15:0] lookup_addr,
    output logic        hit,
    output logic [7:0]  rd_data
);

    logic        valid;
    logic [15:0] tag;
    logic [7:0]  data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= 16'h0000;
            data  <= 8'h00;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (wr_en) begin
            valid <= 1'b1;
            tag   <= wr_tag;
            data  <= wr_data;
        end
    end

    assign hit     = valid && (tag == lookup_addr);
    assign rd_data = data;

endmodule

// File: rtl/emc_xrom_fetch.sv
// ---------------------------------------------------------------------------
// emc_xrom_fetch
// External program-memory fetch controller for the EMC08 core. Turns CPU
// byte-fetch requests into PSEN_B/OE_B strobes on the off-chip 64Kx8 ROM and
// returns the byte with a one-cycle ack. All outputs are registered.
// Parameters:
//   WAIT_STATES  : extra STROBE cycles before sampling ROM data (0..7)
// Ports:
//   xrom_clock_i : core clock, rising edge
//   xrom_reset_i : asynchronous active-low reset
//   bus          : emc_xrom_fetch_if.slave (CPU handshake + ROM pads)
// Build option:
//   EMC_XROM_PREFETCH_EN : after each acked fetch, speculatively fetch the
//   next sequential byte into a one-entry buffer (emc_xrom_pfbuf).
// ---------------------------------------------------------------------------
module emc_xrom_fetch
    import emc_xrom_fetch_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input logic               xrom_clock_i,
    input logic               xrom_reset_i,
    emc_xrom_fetch_if.slave   bus
);

    localparam int          WAIT_CLAMPED = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
    localparam logic [2:0]  WAIT_LOAD    = 3'(WAIT_CLAMPED);

    xrom_state_t state;
    logic [2:0]  wait_cnt;
    logic [15:0] addr_q;
    logic        ack_q;
    logic [7:0]  data_q;
    logic        busy_q;
    logic        psen_b_q;
    logic        oe_b_q;

    // redirect: a demand request arrived for a different address while a
    // speculative fetch is on the bus. spec_now: the fetch on the bus is
    // still speculative after this cycle's request has been considered.
    logic redirect;
    logic spec_now;

`ifdef EMC_XROM_PREFETCH_EN
    logic        spec_q;
    logic        pend_q;
    logic [15:0] last_addr_q;
    logic        buf_hit;
    logic [7:0]  buf_data;
    logic        buf_wr;
    logic        buf_clr;
    logic        addr_match;

    assign addr_match = (bus.xrom_addr_i == addr_q);
    assign redirect   = spec_q && bus.xrom_req_i && !addr_match;
    assign spec_now   = spec_q && !(bus.xrom_req_i && addr_match);

    // Speculative result lands in the buffer on the last STROBE edge.
    assign buf_wr  = (state == ST_STROBE) && (wait_cnt == 3'd0) &&
                     !bus.xrom_abort_i && !redirect && spec_now;
    // A new speculative fetch replaces the entry, so drop the old one.
    assign buf_clr = bus.xrom_abort_i ||
                     ((state == ST_IDLE) && !bus.xrom_req_i && pend_q);

    emc_xrom_pfbuf u_pfbuf (
        .clk         (xrom_clock_i),
        .rst_n       (xrom_reset_i),
        .wr_en       (buf_wr),
        .clr         (buf_clr),
        .wr_tag      (addr_q),
        .wr_data     (bus.xrom_data_i),
        .lookup_addr (bus.xrom_addr_i),
        .hit         (buf_hit),
        .rd_data     (buf_data)
    );
`else
    assign redirect = 1'b0;
    assign spec_now = 1'b0;
`endif

    // Single FSM with registered pad and handshake outputs. Outputs are set
    // on the transition into a state so they are valid for its whole cycle.
    always_ff @(posedge xrom_clock_i or negedge xrom_reset_i) begin
        if (!xrom_reset_i) begin
            state    <= ST_IDLE;
            wait_cnt <= 3'd0;
            addr_q   <= XROM_RESET_ADDR;
            ack_q    <= 1'b0;
            data_q   <= 8'h00;
            busy_q   <= 1'b0;
            psen_b_q <= 1'b1;
            oe_b_q   <= 1'b1;
`ifdef EMC_XROM_PREFETCH_EN
            spec_q      <= 1'b0;
            pend_q      <= 1'b0;
            last_addr_q <= XROM_RESET_ADDR;
`endif
        end else begin
            ack_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Abort beats a simultaneous request; the request is
                    // picked up once abort drops.
                    if (bus.xrom_abort_i) begin
`ifdef EMC_XROM_PREFETCH_EN
                        pend_q <= 1'b0;
`endif
                    end else if (bus.xrom_req_i) begin
`ifdef EMC_XROM_PREFETCH_EN
                        pend_q <= 1'b0;
                        spec_q <= 1'b0;
                        if (buf_hit) begin
                            state       <= ST_DONE;
                            ack_q       <= 1'b1;
                            data_q      <= buf_data;
                            busy_q      <= 1'b1;
                            last_addr_q <= bus.xrom_addr_i;
                        end else
`endif
                        begin
                            state    <= ST_ADDR;
                            addr_q   <= bus.xrom_addr_i;
                            busy_q   <= 1'b1;
                            psen_b_q <= 1'b0;
                            oe_b_q   <= 1'b1;
                        end
                    end
`ifdef EMC_XROM_PREFETCH_EN
                    else if (pend_q) begin
                        pend_q   <= 1'b0;
                        spec_q   <= 1'b1;
                        state    <= ST_ADDR;
                        addr_q   <= next_addr(last_addr_q);
                        busy_q   <= 1'b1;
                        psen_b_q <= 1'b0;
                        oe_b_q   <= 1'b1;
                    end
`endif
                end

                ST_ADDR, ST_STROBE: begin
                    if (bus.xrom_abort_i) begin
                        state    <= ST_IDLE;
                        wait_cnt <= 3'd0;
                        busy_q   <= 1'b0;
                        psen_b_q <= 1'b1;
                        oe_b_q   <= 1'b1;
`ifdef EMC_XROM_PREFETCH_EN
                        spec_q   <= 1'b0;
`endif
                    end else if (redirect) begin
                        // Abandon the speculative fetch and restart the
                        // address phase with the demanded address.
                        state    <= ST_ADDR;
                        addr_q   <= bus.xrom_addr_i;
                        wait_cnt <= 3'd0;
                        psen_b_q <= 1'b0;
                        oe_b_q   <= 1'b1;
`ifdef EMC_XROM_PREFETCH_EN
                        spec_q   <= 1'b0;
`endif
                    end else if (state == ST_ADDR) begin
                        state    <= ST_STROBE;
                        wait_cnt <= WAIT_LOAD;
                        oe_b_q   <= 1'b0;
`ifdef EMC_XROM_PREFETCH_EN
                        spec_q   <= spec_now;
`endif
                    end else if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
`ifdef EMC_XROM_PREFETCH_EN
                        spec_q   <= spec_now;
`endif
                    end else begin
                        psen_b_q <= 1'b1;
                        oe_b_q   <= 1'b1;
`ifdef EMC_XROM_PREFETCH_EN
                        spec_q   <= 1'b0;
`endif
                        if (spec_now) begin
                            // Speculative byte goes to the buffer, not the CPU.
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state  <= ST_DONE;
                            ack_q  <= 1'b1;
                            data_q <= bus.xrom_data_i;
`ifdef EMC_XROM_PREFETCH_EN
                            last_addr_q <= addr_q;
`endif
                        end
                    end
                end

                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
`ifdef EMC_XROM_PREFETCH_EN
                    pend_q <= !bus.xrom_abort_i;
`endif
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.xrom_ack_o    = ack_q;
    assign bus.xrom_data_o   = data_q;
    assign bus.xrom_busy_o   = busy_q;
    assign bus.xrom_adr_hi_o = addr_q[15:8];
    assign bus.xrom_adr_lo_o = addr_q[7:0];
    assign bus.xrom_psen_b_o = psen_b_q;
    assign bus.xrom_oe_b_o   = oe_b_q;

endmodule
